// File: rtl/ex_issue_stage.sv
// Two-entry issue buffer between decode and the ALU: holds decoded ops, keeps
// their operands fresh from write-back and forwards EX/MEM and MEM/WB at the head.
module ex_issue_stage #(
    parameter int bit_width  = 32,
    parameter int reg_addr_w = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [3:0]            id_aluop,
    input  logic [reg_addr_w-1:0] id_rs_addr,
    input  logic [reg_addr_w-1:0] id_rt_addr,
    input  logic [bit_width-1:0]  id_rs_data,
    input  logic [bit_width-1:0]  id_rt_data,
    input  logic [bit_width-1:0]  id_imm,
    input  logic                  id_use_imm,
    input  logic [reg_addr_w-1:0] id_rd_addr,
    input  logic                  id_regwrite,
    input  logic                  exmem_regwrite,
    input  logic [reg_addr_w-1:0] exmem_rd,
    input  logic [bit_width-1:0]  exmem_res,
    input  logic                  memwb_regwrite,
    input  logic [reg_addr_w-1:0] memwb_rd,
    input  logic [bit_width-1:0]  memwb_res,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [bit_width-1:0]  ex_A,
    output logic [bit_width-1:0]  ex_B,
    output logic [3:0]            ex_aluop,
    output logic [reg_addr_w-1:0] ex_rd,
    output logic                  ex_regwrite
);

    localparam logic [bit_width-1:0] BW_VAL = bit_width'(bit_width);

    logic [1:0]            r_count;
    logic                  r_head;
    logic                  r_tail;
    logic [3:0]            r_aluop    [2];
    logic [reg_addr_w-1:0] r_rs_addr  [2];
    logic [reg_addr_w-1:0] r_rt_addr  [2];
    logic [bit_width-1:0]  r_rs_data  [2];
    logic [bit_width-1:0]  r_rt_data  [2];
    logic [bit_width-1:0]  r_imm      [2];
    logic                  r_use_imm  [2];
    logic [reg_addr_w-1:0] r_rd       [2];
    logic                  r_regwrite [2];

    logic                  w_push;
    logic                  w_pop;
    logic                  w_snoop;
    logic [1:0]            w_entry_valid;
    logic [bit_width-1:0]  w_push_rs_data;
    logic [bit_width-1:0]  w_push_rt_data;
    logic [reg_addr_w-1:0] w_h_rs;
    logic [reg_addr_w-1:0] w_h_rt;
    logic [bit_width-1:0]  w_fwd_a;
    logic [bit_width-1:0]  w_fwd_b;
    logic [bit_width-1:0]  w_b_raw;
    logic [bit_width-1:0]  w_b_final;
    logic                  w_is_shift;

    assign ex_valid = (r_count != 2'd0);
    assign id_ready = !rst && (r_count != 2'd2);
    assign w_push   = id_valid && id_ready;
    assign w_pop    = ex_valid && ex_ready;
    assign w_snoop  = memwb_regwrite && (memwb_rd != '0);

    assign w_entry_valid[0] = (r_count == 2'd2) || (r_count == 2'd1 && r_head == 1'b0);
    assign w_entry_valid[1] = (r_count == 2'd2) || (r_count == 2'd1 && r_head == 1'b1);

    // The incoming op sees the same write-back as held ops, so it never stores stale data.
    assign w_push_rs_data = (w_snoop && id_rs_addr == memwb_rd) ? memwb_res : id_rs_data;
    assign w_push_rt_data = (w_snoop && id_rt_addr == memwb_rd) ? memwb_res : id_rt_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_aluop[i]    <= '0;
                r_rs_addr[i]  <= '0;
                r_rt_addr[i]  <= '0;
                r_rs_data[i]  <= '0;
                r_rt_data[i]  <= '0;
                r_imm[i]      <= '0;
                r_use_imm[i]  <= 1'b0;
                r_rd[i]       <= '0;
                r_regwrite[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_snoop && w_entry_valid[i]) begin
                    if (r_rs_addr[i] == memwb_rd) r_rs_data[i] <= memwb_res;
                    if (r_rt_addr[i] == memwb_rd) r_rt_data[i] <= memwb_res;
                end
            end
            if (flush) begin
                r_count <= 2'd0;
                r_head  <= 1'b0;
                r_tail  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_aluop[r_tail]    <= id_aluop;
                    r_rs_addr[r_tail]  <= id_rs_addr;
                    r_rt_addr[r_tail]  <= id_rt_addr;
                    r_rs_data[r_tail]  <= w_push_rs_data;
                    r_rt_data[r_tail]  <= w_push_rt_data;
                    r_imm[r_tail]      <= id_imm;
                    r_use_imm[r_tail]  <= id_use_imm;
                    r_rd[r_tail]       <= id_rd_addr;
                    r_regwrite[r_tail] <= id_regwrite;
                    r_tail             <= !r_tail;
                end
                if (w_pop) r_head <= !r_head;
                if (w_push && !w_pop)      r_count <= r_count + 2'd1;
                else if (!w_push && w_pop) r_count <= r_count - 2'd1;
            end
        end
    end

    assign w_h_rs = r_rs_addr[r_head];
    assign w_h_rt = r_rt_addr[r_head];

    // EX/MEM is younger than MEM/WB, so it takes priority; r0 is never forwarded.
    always_comb begin
        w_fwd_a = r_rs_data[r_head];
        if (w_h_rs != '0 && exmem_regwrite && exmem_rd == w_h_rs)
            w_fwd_a = exmem_res;
        else if (w_h_rs != '0 && memwb_regwrite && memwb_rd == w_h_rs)
            w_fwd_a = memwb_res;

        w_fwd_b = r_rt_data[r_head];
        if (w_h_rt != '0 && exmem_regwrite && exmem_rd == w_h_rt)
            w_fwd_b = exmem_res;
        else if (w_h_rt != '0 && memwb_regwrite && memwb_rd == w_h_rt)
            w_fwd_b = memwb_res;

        w_b_raw    = r_use_imm[r_head] ? r_imm[r_head] : w_fwd_b;
        w_is_shift = (r_aluop[r_head][3:1] == 3'b011);
        w_b_final  = (w_is_shift && w_b_raw > BW_VAL) ? BW_VAL : w_b_raw;
    end

    assign ex_A        = ex_valid ? w_fwd_a : '0;
    assign ex_B        = ex_valid ? w_b_final : '0;
    assign ex_aluop    = ex_valid ? r_aluop[r_head] : 4'd0;
    assign ex_rd       = ex_valid ? r_rd[r_head] : '0;
    assign ex_regwrite = ex_valid && r_regwrite[r_head];

endmodule
